// File: rtl/axi_clint_if.sv
// rtl/axi_clint_if.sv - five-channel AXI-lite style bus between a requester and the CLINT
interface axi_clint_if #(
  parameter int DATA_LEN  = 32,
  parameter int STROB_LEN = DATA_LEN / 8
);
  logic                 awvalid;
  logic                 awready;
  logic [DATA_LEN-1:0]  waddr;
  logic                 wvalid;
  logic                 wready;
  logic [DATA_LEN-1:0]  wdata;
  logic [STROB_LEN-1:0] wstrob;
  logic                 bvalid;
  logic                 bready;
  logic [2:0]           bresp;
  logic                 arvalid;
  logic                 arready;
  logic [DATA_LEN-1:0]  raddr;
  logic                 rvalid;
  logic                 rready;
  logic [DATA_LEN-1:0]  rdata;
  logic [2:0]           rresp;

  modport master (
    output awvalid, waddr, wvalid, wdata, wstrob, bready, arvalid, raddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, waddr, wvalid, wdata, wstrob, bready, arvalid, raddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_clint.sv
// rtl/axi_clint.sv - core-local timer: 64-bit mtime/mtimecmp behind an AXI-lite responder
module axi_clint #(
  parameter int          DATA_LEN  = 32,
  parameter int          STROB_LEN = DATA_LEN / 8,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  axi_clint_if.slave  bus,
  output logic        timer_irq
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [2:0] RESP_OKAY   = 3'b000;
  localparam logic [2:0] RESP_DECERR = 3'b011;

  typedef enum logic [2:0] {
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_TIME_LO,
    SEL_TIME_HI,
    SEL_NONE
  } sel_e;

  typedef enum logic { R_IDLE, R_RESP } r_state_e;
  typedef enum logic { W_IDLE, W_RESP } w_state_e;

  // Whole-word masking keeps every address bit in the compare while ignoring addr[1:0].
  function automatic sel_e decode(input logic [DATA_LEN-1:0] addr);
    logic [DATA_LEN-1:0] word;
    word = addr & ~32'h3;
    if (word == BASE_ADDR + 32'h4000)      return SEL_CMP_LO;
    else if (word == BASE_ADDR + 32'h4004) return SEL_CMP_HI;
    else if (word == BASE_ADDR + 32'hBFF8) return SEL_TIME_LO;
    else if (word == BASE_ADDR + 32'hBFFC) return SEL_TIME_HI;
    else                                   return SEL_NONE;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  logic [63:0]          mtime, mtime_nxt;
  logic [63:0]          mtimecmp, mtimecmp_nxt;
  logic [PW-1:0]        presc;
  logic                 tick;

  r_state_e             r_state, r_state_nxt;
  logic                 rd_fire;
  logic [DATA_LEN-1:0]  rdata_q;
  logic [2:0]           rresp_q;

  w_state_e             w_state, w_state_nxt;
  logic                 aw_held, w_held;
  logic [DATA_LEN-1:0]  aw_addr;
  logic [DATA_LEN-1:0]  w_data;
  logic [STROB_LEN-1:0] w_strb;
  logic                 aw_fire, w_fire, b_fire;
  logic                 wr_apply;
  sel_e                 wr_sel;
  logic [2:0]           bresp_q;

  // Prescaler and tick
  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Read channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    rd_fire     = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (bus.arvalid) begin
          rd_fire     = 1'b1;
          r_state_nxt = R_RESP;
        end
      end
      R_RESP: begin
        if (bus.rready) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (rd_fire) begin
      rresp_q <= RESP_OKAY;
      case (decode(bus.raddr))
        SEL_CMP_LO:  rdata_q <= mtimecmp[31:0];
        SEL_CMP_HI:  rdata_q <= mtimecmp[63:32];
        SEL_TIME_LO: rdata_q <= mtime[31:0];
        SEL_TIME_HI: rdata_q <= mtime[63:32];
        default: begin
          rdata_q <= '0;
          rresp_q <= RESP_DECERR;
        end
      endcase
    end
  end

  assign bus.arready = (r_state == R_IDLE);
  assign bus.rvalid  = (r_state == R_RESP);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

  // Write channel: AW and W are parked independently until both are present
  assign bus.awready = (w_state == W_IDLE) && !aw_held;
  assign bus.wready  = (w_state == W_IDLE) && !w_held;
  assign aw_fire     = bus.awvalid && bus.awready;
  assign w_fire      = bus.wvalid && bus.wready;
  assign b_fire      = (w_state == W_RESP) && bus.bready;
  assign wr_sel      = decode(aw_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    wr_apply    = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_held && w_held) begin
          wr_apply    = 1'b1;
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (bus.bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (aw_fire) begin
        aw_held <= 1'b1;
        aw_addr <= bus.waddr;
      end
      if (w_fire) begin
        w_held <= 1'b1;
        w_data <= bus.wdata;
        w_strb <= bus.wstrob;
      end
      if (b_fire) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bresp_q <= RESP_OKAY;
    end else if (wr_apply) begin
      bresp_q <= (wr_sel == SEL_NONE) ? RESP_DECERR : RESP_OKAY;
    end
  end

  assign bus.bvalid = (w_state == W_RESP);
  assign bus.bresp  = bresp_q;

  // Counter and compare registers; a write to either mtime half overrides the tick
  always_comb begin
    mtime_nxt    = mtime;
    mtimecmp_nxt = mtimecmp;
    if (tick) mtime_nxt = mtime + 64'd1;
    if (wr_apply) begin
      case (wr_sel)
        SEL_CMP_LO:  mtimecmp_nxt = {mtimecmp[63:32], merge(mtimecmp[31:0], w_data, w_strb)};
        SEL_CMP_HI:  mtimecmp_nxt = {merge(mtimecmp[63:32], w_data, w_strb), mtimecmp[31:0]};
        SEL_TIME_LO: mtime_nxt    = {mtime[63:32], merge(mtime[31:0], w_data, w_strb)};
        SEL_TIME_HI: mtime_nxt    = {merge(mtime[63:32], w_data, w_strb), mtime[31:0]};
        default: begin
          mtime_nxt    = (tick) ? mtime + 64'd1 : mtime;
          mtimecmp_nxt = mtimecmp;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime     <= 64'd0;
      mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      timer_irq <= 1'b0;
    end else begin
      mtime     <= mtime_nxt;
      mtimecmp  <= mtimecmp_nxt;
      timer_irq <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: doc/axi_clint.md
# axi_clint

Memory-mapped core-local timer (CLINT subset) acting as a responder on the core's AXI-lite style bus, the slave-side counterpart of the IFU/LSU request ports. It holds a free-running 64-bit `mtime`, a 64-bit `mtimecmp` and drives the machine timer interrupt. It hangs off a slave port of the bus matrix, alongside `sram`, and uses the same five-channel handshake and 3-bit response encoding.

## Interface
- `DATA_LEN`, 32, bus data/address width; only 32 is supported.
- `STROB_LEN`, DATA_LEN/8, write strobe width.
- `BASE_ADDR`, 32'h0200_0000, base of the CLINT window.
- `TICK_DIV`, 1, number of clock cycles per `mtime` increment (≥1).

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `awvalid`  in  1  write address valid.
- `awready`  out  1  write address accepted.
- `waddr`  in  DATA_LEN  write address.
- `wvalid`  in  1  write data valid.
- `wready`  out  1  write data accepted.
- `wdata`  in  DATA_LEN  write data.
- `wstrob`  in  STROB_LEN  byte enables, bit i covers wdata[8i+7:8i].
- `bvalid`  out  1  write response valid.
- `bready`  in  1  write response accepted.
- `bresp`  out  3  3'b000 OKAY, 3'b011 decode error.
- `arvalid`  in  1  read address valid.
- `arready`  out  1  read address accepted.
- `raddr`  in  DATA_LEN  read address.
- `rvalid`  out  1  read data valid.
- `rready`  in  1  read data accepted.
- `rdata`  out  DATA_LEN  read data.
- `rresp`  out  3  same encoding as `bresp`.
- `timer_irq`  out  1  high while `mtime >= mtimecmp` (unsigned 64-bit).

## Operation
- Register map (offset from BASE_ADDR, addr[1:0] ignored): 0x4000 mtimecmp[31:0], 0x4004 mtimecmp[63:32], 0xBFF8 mtime[31:0], 0xBFFC mtime[63:32]. All other addresses decode error.
- Reset: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0, awready=wready=arready=1, bvalid=rvalid=0, bresp=rresp=0, rdata=0, timer_irq=0.
- Prescaler counts 0..TICK_DIV-1; on reaching TICK_DIV-1 it wraps to 0 and mtime increments by 1; mtime wraps 2^64-1 -> 0.
- Read FSM, R_IDLE/R_RESP: in R_IDLE arready=1; on arvalid&arready, rdata/rresp registered from the selected register's value at that edge, go R_RESP. R_RESP: arready=0, rvalid=1, rdata/rresp stable; on rready return R_IDLE. Unmapped read: rdata=0, rresp=3'b011.
- Write FSM, W_IDLE/W_RESP: AW and W captured independently in any order or same cycle; awready drops after AW captured, wready drops after W captured. When both held, the write is applied on the next edge (only strobed bytes change), bvalid=1, bresp set, state W_RESP; on bvalid&bready, awready=wready=1, return W_IDLE. Unmapped write: no state change, bresp=3'b011.
- Write to either mtime half in a cycle suppresses that cycle's increment (written value wins; prescaler not reset). mtimecmp writes do not affect counting.
- Read and write channels operate concurrently and independently.
- timer_irq registered: reflects comparison of the previous cycle's mtime/mtimecmp.

## Timing
- Read: AR handshake at edge N -> rvalid high after N; minimum one read per 2 cycles.
- Write: last of AW/W handshake at edge N -> register updated and bvalid high after edge N+1.
- Outputs hold while valid and not ready; no combinational path from any input to any output.
- Reset asserted mid-transaction: all in-flight transactions dropped, outputs return to reset values immediately.
- timer_irq latency one cycle after the condition becomes true/false.

## Test plan
- Reset, TICK_DIV=1, idle 10 cycles, read 0xBFF8 -> rdata between 10 and 12, rresp=0; read 0x4004 -> 32'hFFFF_FFFF, timer_irq=0.
- Write mtimecmp lo=20, hi=0 (AW before W, then W before AW) -> bresp=0 each; timer_irq rises exactly one cycle after mtime reaches 20.
- Write 0xBFF8 wdata=32'hFFFF_FFFF, 0xBFFC=0 then wait 1 tick -> reads show lo=0, hi=1 (carry).
- Write 0xBFF8 wdata=32'h1234_5678, wstrob=4'b0011 with mtime lo=0 -> lo reads 32'h0000_5678+elapsed ticks.
- Read 0x0 and write 0x8000 -> rresp=3'b011, rdata=0, bresp=3'b011, no register change.
- Hold rready=0 / bready=0 for 5 cycles with concurrent read and write -> rvalid/bvalid, rdata stable, arready/awready stay 0; TICK_DIV=4 -> mtime advances 1 per 4 cycles.
